// File: rtl/disp_share_ctrl.sv
// disp_share_ctrl: arbitrates two sources onto a 4-digit muxed 7-seg display (optional DISP_LZ_SUPPRESS_EN leading-zero blanking).
// Latency: outputs are registered one cycle behind the pc/slot counters; source changes take effect at the next frame.
// Backpressure: none; requests are levels or pulses latched into a pending flag, the display always accepts.
module disp_share_ctrl #(
    parameter int DIV         = 50000,
    parameter int BLANK       = 8,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [15:0] DataA,
    input  logic        ReqB,
    input  logic [15:0] DataB,
    output logic [3:0]  Digit,
    output logic [3:0]  Select,
    output logic        Blank,
    output logic        GntB,
    output logic        FrameTick
);

    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW  = $clog2(HOLD_FRAMES + 1);

    localparam logic [PCW-1:0] PC_LAST   = PCW'(DIV - 1);
    localparam logic [PCW-1:0] PC_BLANK  = PCW'(BLANK);
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_t;

    logic [PCW-1:0] pc;
    logic [1:0]     s;
    state_t         state;
    state_t         state_nxt;
    logic [HW-1:0]  hold;
    logic [HW-1:0]  hold_nxt;
    logic           pend_b;
    logic           pend_b_nxt;
    logic [15:0]    snap_dat;
    logic [15:0]    snap_nxt;

    logic [3:0]     nib;
    logic           in_blank;
    logic           lz_dark;
    logic           lit;

    // Prescaler and slot counter free-run in every state, including OFF.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc <= '0;
            s  <= 2'd0;
        end else if (pc == PC_LAST) begin
            pc <= '0;
            s  <= s + 2'd1;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= OFF;
            hold     <= '0;
            pend_b   <= 1'b0;
            snap_dat <= 16'h0000;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            pend_b   <= pend_b_nxt;
            snap_dat <= snap_nxt;
        end
    end

    // Arbitration happens in the cycle the registered FrameTick is high, so a
    // request seen alongside FrameTick still makes the following frame.
    // Every decision consumes pendB: either B is granted, or B was already
    // showing and a request raised during its hold must not re-grant.
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold;
        snap_nxt   = snap_dat;
        pend_b_nxt = pend_b | ReqB;
        if (FrameTick) begin
            pend_b_nxt = 1'b0;
            if (state == SHOW_B) begin
                if (hold != '0) begin
                    hold_nxt = hold - 1'b1;
                end else if (ReqB) begin
                    hold_nxt = HOLD_LOAD;
                    snap_nxt = DataB;
                end else if (ReqA) begin
                    state_nxt = SHOW_A;
                    snap_nxt  = DataA;
                end else begin
                    state_nxt = OFF;
                end
            end else if (pend_b || ReqB) begin
                state_nxt = SHOW_B;
                hold_nxt  = HOLD_LOAD;
                snap_nxt  = DataB;
            end else if (ReqA) begin
                state_nxt = SHOW_A;
                snap_nxt  = DataA;
            end else begin
                state_nxt = OFF;
            end
        end
    end

    // Decode uses the next-state view so a boundary decision lands exactly on
    // the first output cycle of the new frame.
    always_comb begin
        nib      = snap_nxt[{s, 2'b00} +: 4];
        in_blank = (pc < PC_BLANK);
        lz_dark  = 1'b0;
`ifdef DISP_LZ_SUPPRESS_EN
        if (state_nxt != OFF) begin
            case (s)
                2'd1:    lz_dark = (snap_nxt[15:4]  == 12'h000);
                2'd2:    lz_dark = (snap_nxt[15:8]  == 8'h00);
                2'd3:    lz_dark = (snap_nxt[15:12] == 4'h0);
                default: lz_dark = 1'b0;
            endcase
        end
`else
        lz_dark  = 1'b0;
`endif
        lit = (state_nxt != OFF) && !in_blank && !lz_dark;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Digit     <= 4'h0;
            Select    <= 4'b0000;
            Blank     <= 1'b1;
            GntB      <= 1'b0;
            FrameTick <= 1'b0;
        end else begin
            Digit     <= (state_nxt == OFF) ? 4'h0 : nib;
            Select    <= lit ? (4'b0001 << s) : 4'b0000;
            Blank     <= in_blank && !lz_dark;
            GntB      <= (state_nxt == SHOW_B);
            FrameTick <= (pc == PC_LAST) && (s == 2'd3);
        end
    end

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Randomized scoreboard bench for disp_share_ctrl; a frame-level model predicts every output cycle.
module tb_disp_share_ctrl;

    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int HF    = 3;
    localparam int FRAME = 4 * DIV;

    localparam int M_OFF = 0;
    localparam int M_A   = 1;
    localparam int M_B   = 2;

    typedef struct packed {
        logic [3:0] digit;
        logic [3:0] sel;
        logic       blank;
        logic       gnt;
        logic       ft;
    } obs_t;

    logic        Clk;
    logic        Reset;
    logic        ReqA;
    logic [15:0] DataA;
    logic        ReqB;
    logic [15:0] DataB;
    logic [3:0]  Digit;
    logic [3:0]  Select;
    logic        Blank;
    logic        GntB;
    logic        FrameTick;

    disp_share_ctrl #(.DIV(DIV), .BLANK(BLANK), .HOLD_FRAMES(HF)) dut (
        .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .DataA(DataA), .ReqB(ReqB), .DataB(DataB),
        .Digit(Digit), .Select(Select), .Blank(Blank), .GntB(GntB), .FrameTick(FrameTick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    bit   sb_on = 0;

    // Reference model: what is on screen this frame, and for how many frames B has been shown.
    int   edges   = 0;
    int   m_mode  = M_OFF;
    int   m_val   = 0;
    int   b_shown = 0;
    bit   m_pend  = 0;

    function automatic obs_t expect_at(int p);
        obs_t o;
        int   slot;
        int   pcv;
        bit   dark;
        slot = (p / DIV) % 4;
        pcv  = p % DIV;
        dark = 0;
`ifdef DISP_LZ_SUPPRESS_EN
        if (m_mode != M_OFF && slot != 0 && (m_val >> (4 * slot)) == 0) dark = 1;
`endif
        o.ft    = (slot == 3) && (pcv == DIV - 1);
        o.gnt   = (m_mode == M_B);
        o.blank = (pcv < BLANK) && !dark;
        o.sel   = (m_mode != M_OFF && pcv >= BLANK && !dark) ? 4'(1 << slot) : 4'b0000;
        o.digit = (m_mode == M_OFF) ? 4'h0 : 4'((m_val >> (4 * slot)) & 15);
        return o;
    endfunction

    task automatic frame_boundary();
        bit want_b;
        want_b = m_pend || ReqB;
        m_pend = 0;
        if (m_mode == M_B && b_shown < HF) begin
            b_shown++;
        end else if (m_mode == M_B && ReqB) begin
            b_shown = 1;
            m_val   = int'(DataB);
        end else if (m_mode != M_B && want_b) begin
            m_mode  = M_B;
            b_shown = 1;
            m_val   = int'(DataB);
        end else if (ReqA) begin
            m_mode = M_A;
            m_val  = int'(DataA);
        end else begin
            m_mode = M_OFF;
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            edges   = 0;
            m_mode  = M_OFF;
            m_val   = 0;
            b_shown = 0;
            m_pend  = 0;
            exp_q.push_back('{digit: 4'h0, sel: 4'b0000, blank: 1'b1, gnt: 1'b0, ft: 1'b0});
            sb_on = 1;
        end else if (sb_on) begin
            edges++;
            // The cycle just displayed was the last one of a frame: arbitrate now.
            if (edges >= 2 && ((edges - 2) % FRAME) == FRAME - 1) frame_boundary();
            else if (ReqB) m_pend = 1;
            exp_q.push_back(expect_at(edges - 1));
        end
    end

    always @(negedge Clk) begin
        obs_t e;
        obs_t a;
        if (sb_on) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty t=%0t: no expected entry for this output cycle", $time);
            end else begin
                e = exp_q.pop_front();
                a = '{digit: Digit, sel: Select, blank: Blank, gnt: GntB, ft: FrameTick};
                if (a !== e)  begin
                    errors++;
                    $display("FAIL outputs t=%0t got digit=%h sel=%b blank=%b gnt=%b ft=%b, expected digit=%h sel=%b blank=%b gnt=%b ft=%b",
                             $time, a.digit, a.sel, a.blank, a.gnt, a.ft, e.digit, e.sel, e.blank, e.gnt, e.ft);
                end
            end
            checks++;
            if (!$onehot0(Select)) begin
                errors++;
                $display("FAIL select_onehot t=%0t got sel=%b, expected at most one bit", $time, Select);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge Clk);
    endtask

    // Advance until the output cycle about to be shown is frame position pos.
    task automatic align(int pos);
        for (int i = 0; i < FRAME + 1; i++) begin
            if ((edges % FRAME) == pos) return;
            @(negedge Clk);
        end
    endtask

    initial begin
        int rb_left;
        Reset = 1'b1;
        ReqA  = 1'b0;
        ReqB  = 1'b0;
        DataA = 16'h0000;
        DataB = 16'h0000;
        step(3);

        // Steady A: frame 1 dark, then 4/3/2/1.
        Reset = 1'b0;
        ReqA  = 1'b1;
        DataA = 16'h1234;
        step(3 * FRAME);

        // Single-cycle B pulse mid-frame; later DataB changes must not be resampled.
        align(15);
        ReqB  = 1'b1;
        DataB = 16'hBEEF;
        step(1);
        ReqB  = 1'b0;
        step(50);
        DataB = 16'(($urandom));
        step(4 * FRAME);

        // DataA change in mid-slot 1 only shows from the next frame.
        align(DIV + 5);
        DataA = 16'h5678;
        step(2 * FRAME);

        // ReqB held for 10 frames with DataB wandering, then released.
        ReqB = 1'b1;
        for (int i = 0; i < 10 * FRAME; i++) begin
            if (i % 13 == 0) DataB = 16'($urandom);
            step(1);
        end
        ReqB = 1'b0;
        step(6 * FRAME);

        // Reset mid-slot 2 while B is displayed.
        align(5);
        ReqB  = 1'b1;
        DataB = 16'hBEEF;
        step(1);
        ReqB  = 1'b0;
        step(FRAME);
        align(2 * DIV + 4);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        step(3 * FRAME);

        // Leading-zero patterns, then A withdrawn (OFF) and restored.
        DataA = 16'h0050;
        step(2 * FRAME);
        DataA = 16'h0000;
        step(2 * FRAME);
        ReqA = 1'b0;
        step(2 * FRAME);
        ReqA  = 1'b1;
        DataA = 16'h0A0C;
        step(2 * FRAME);

        // Randomized traffic with occasional resets.
        rb_left = 0;
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 99) == 0) ReqA = ~ReqA;
            if ($urandom_range(0, 19) == 0) DataA = 16'($urandom);
            if ($urandom_range(0, 19) == 0) DataB = 16'($urandom);
            if (rb_left == 0 && $urandom_range(0, 149) == 0) rb_left = $urandom_range(1, 6);
            ReqB = (rb_left > 0);
            if (rb_left > 0) rb_left--;
            Reset = ($urandom_range(0, 1499) == 0);
            step(1);
        end
        Reset = 1'b0;
        ReqB  = 1'b0;
        step(2);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_share_ctrl.md
# disp_share_ctrl

Scan controller and arbiter for the 4-digit multiplexed 7-segment display. Shares the display between a background source (A, normal readout) and a priority source (B, alert/message), snapshots the winning 16-bit value once per frame, and sequences the digit scan with a prescaler and inter-digit blanking. Its outputs drive one shared decoder7448 and the common-cathode digit selects directly.

## Interface

- DIV, 50000: clock cycles per digit slot; legal when DIV >= 2.
- BLANK, 8: blanking cycles at the start of each slot; legal when 0 <= BLANK < DIV.
- HOLD_FRAMES, 250: minimum number of frames B is shown per grant; legal when >= 1.

- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- ReqA  in  1  level: A wants the display.
- DataA  in  16  A value, 4 hex nibbles, [3:0] = digit 0.
- ReqB  in  1  level or single-cycle pulse: B wants the display.
- DataB  in  16  B value, same packing.
- Digit  out  4  nibble for the current slot, fed to the decoder.
- Select  out  4  one-hot digit enable; 0000 = dark.
- Blank  out  1  high during the blanking part of a slot.
- GntB  out  1  high for every frame in which B is displayed.
- FrameTick  out  1  one-cycle pulse in the last cycle of slot 3.

## Operation

- Prescaler `pc` counts 0..DIV-1. Slot `s` counts 0..3 and advances when pc = DIV-1. One frame is 4*DIV cycles.
- Within slot s:
  - Blank = 1 and Select = 0000 while pc < BLANK.
  - Otherwise Select[s] = 1, provided the state is not OFF.
  - Digit = snapshot[4s+3:4s] for the whole slot.
- Pending flag `pendB`:
  - Set on any cycle with ReqB = 1.
  - Cleared at the frame boundary where B is granted.
  - A pulse of any length is never lost.
- FSM states are OFF, SHOW_A and SHOW_B. Decisions are taken only at the frame boundary (the FrameTick cycle):
  - Any state, with pendB or ReqB set, and not in SHOW_B holding: go to SHOW_B, load hold = HOLD_FRAMES-1, snapshot DataB.
  - In SHOW_B with hold > 0: decrement hold, keep the snapshot. A new DataB is not re-sampled.
  - In SHOW_B with hold = 0 and ReqB = 1: reload hold = HOLD_FRAMES-1 and re-snapshot DataB.
  - In SHOW_B with hold = 0 and ReqB = 0: go to SHOW_A if ReqA, else OFF. pendB set during the hold does not re-grant.
  - In SHOW_A or OFF without a B request: go to SHOW_A with a DataA snapshot if ReqA, else OFF.
- In OFF, scanning continues; Select = 0000 and Digit = 0.
- GntB = 1 exactly while the state is SHOW_B.
- Input data changes mid-frame never alter the frame being displayed.

## Timing

- Reset values: pc = 0, s = 0, state OFF, hold = 0, pendB = 0, snapshot = 0, Select = 0000, Digit = 0, Blank = 1, GntB = 0, FrameTick = 0.
- The first slot 0 begins on the first rising edge with Reset low.
- The first frame after reset is always dark. The earliest visible frame is frame 2.
- All outputs are registered and reflect the current pc and s with a fixed, uniform one-cycle pipeline.
- Boundary behaviour:
  - A new state takes effect from the first cycle of the next slot 0.
  - Select never has two bits high, including across slot and frame wrap.
  - Reset asserted mid-slot returns every register to its reset value on that edge, whatever the state.
  - ReqB asserted in the FrameTick cycle itself is honoured at that boundary.

## Configuration

- DISP_LZ_SUPPRESS_EN defined: leading-zero suppression is enabled.
  - A slot s in 1..3 stays dark (Select = 0000, Blank = 0) when snapshot nibbles s..3 are all zero.
  - Slot 0 is always lit.
  - Suppression applies to both sources.
- DISP_LZ_SUPPRESS_EN undefined: all four digits are always lit in SHOW_A and SHOW_B.

## Test plan

Bench parameters: DIV = 10, BLANK = 2, HOLD_FRAMES = 3.

- ReqA = 1, DataA = 16'h1234 after reset:
  - Frame 1 is dark.
  - From frame 2, each slot gives Select = 0001/0010/0100/1000 for cycles 2..9 of that slot, with Digit = 4/3/2/1.
  - FrameTick pulses every 40 cycles.
- Steady A, then a 1-cycle ReqB pulse mid-frame with DataB = 16'hBEEF:
  - The next 3 frames show F, E, E, B with GntB = 1.
  - The display then returns to A.
- ReqB held high for 10 frames: B is shown continuously with a hold reload every 3 frames. After release, B finishes the current hold, then A resumes.
- DataA changes 1234 -> 5678 in mid-slot 1: the rest of the frame still shows 1234, and the next frame shows 5678.
- Reset asserted for 1 cycle mid-slot 2 in SHOW_B: all outputs return to their reset values on the next edge, then the dark frame and re-arbitration follow.
- With DISP_LZ_SUPPRESS_EN defined and DataA = 16'h0050:
  - Slots 2 and 3 stay dark.
  - Slot 1 shows 5 and slot 0 shows 0.
  - DataA = 16'h0000 lights slot 0 only.
